// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : ID -> issue -> ALU handshake/bus bundle for alu_issue_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OPW-1:0]  alu_op;
    logic            illegal;

    // Environment side: ID producer plus EX/MEM consumer.
    modport master (
        output flush, in_valid, opcode, funct3, funct7_5, pc,
               rs1_data, rs2_data, imm, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, illegal
    );

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5, pc,
               rs1_data, rs2_data, imm, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : RV32I -> ALU opcode/operand issue stage, 2-entry skid output.
// Options  : ALU_ISSUE_ILLEGAL_EN - flag unsupported encodings, count them.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [OPW-1:0] c_ALU_AND  = OPW'(0);
    localparam logic [OPW-1:0] c_ALU_OR   = OPW'(1);
    localparam logic [OPW-1:0] c_ALU_ADD  = OPW'(2);
    localparam logic [OPW-1:0] c_ALU_SUB  = OPW'(3);
    localparam logic [OPW-1:0] c_ALU_SLT  = OPW'(4);
    localparam logic [OPW-1:0] c_ALU_SLTU = OPW'(5);
    localparam logic [OPW-1:0] c_ALU_XOR  = OPW'(6);
    localparam logic [OPW-1:0] c_ALU_SLL  = OPW'(8);
    localparam logic [OPW-1:0] c_ALU_SRA  = OPW'(9);
    localparam logic [OPW-1:0] c_ALU_SRL  = OPW'(10);

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic c_ILL_EN = 1'b1;
`else
    localparam logic c_ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  op;
        logic            ill;
    } entry_t;

    entry_t          w_dec;
    logic [XLEN-1:0] w_src;
    logic            w_accept;
    logic            w_drain;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;

    assign w_src    = (bus.opcode == c_OPC_OP) ? bus.rs2_data : bus.imm;
    assign w_accept = bus.in_valid & ~skid_valid_q;
    assign w_drain  = main_valid_q & bus.out_ready;

    always_comb begin
        w_dec    = '0;
        w_dec.op = c_ALU_ADD;
        case (bus.opcode)
            c_OPC_OP, c_OPC_OPIMM: begin
                w_dec.a = bus.rs1_data;
                case (bus.funct3)
                    3'b000:  w_dec.op = (bus.opcode == c_OPC_OP && bus.funct7_5)
                                        ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  w_dec.op = c_ALU_SLL;
                    3'b010:  w_dec.op = c_ALU_SLT;
                    3'b011:  w_dec.op = c_ALU_SLTU;
                    3'b100:  w_dec.op = c_ALU_XOR;
                    3'b101:  w_dec.op = bus.funct7_5 ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  w_dec.op = c_ALU_OR;
                    default: w_dec.op = c_ALU_AND;
                endcase
                // Shifts only consume the 5-bit shift amount.
                if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) begin
                    w_dec.b = {{(XLEN-5){1'b0}}, w_src[4:0]};
                end else begin
                    w_dec.b = w_src;
                end
            end
            c_OPC_LOAD, c_OPC_STORE: begin
                w_dec.a = bus.rs1_data;
                w_dec.b = bus.imm;
            end
            c_OPC_BRANCH: begin
                w_dec.a = bus.rs1_data;
                w_dec.b = bus.rs2_data;
                case (bus.funct3)
                    3'b000, 3'b001: w_dec.op = c_ALU_SUB;
                    3'b100, 3'b101: w_dec.op = c_ALU_SLT;
                    3'b110, 3'b111: w_dec.op = c_ALU_SLTU;
                    default: begin
                        w_dec.a   = '0;
                        w_dec.b   = '0;
                        w_dec.ill = c_ILL_EN;
                    end
                endcase
            end
            c_OPC_LUI: begin
                w_dec.b = bus.imm;
            end
            c_OPC_AUIPC: begin
                w_dec.a = bus.pc;
                w_dec.b = bus.imm;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                w_dec.a = bus.pc;
                w_dec.b = XLEN'(4);
            end
            default: begin
                w_dec.ill = c_ILL_EN;
            end
        endcase
    end

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || w_drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                main_d       = w_dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            skid_d       = w_dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic [15:0] illegal_cnt_q;

    // Accepts dropped by a same-cycle flush are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (w_accept && !bus.flush && w_dec.ill && illegal_cnt_q != 16'hFFFF) begin
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end
`endif

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.alu_a     = main_q.a;
    assign bus.alu_b     = main_q.b;
    assign bus.alu_op    = main_q.op;
    assign bus.illegal   = main_q.ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed + random bench for alu_issue_ctrl against a queue model.
// Options  : ALU_ISSUE_ILLEGAL_EN - expects illegal flag and counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;
    localparam int XLEN = 32;
    localparam int OPW  = 4;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit c_ILL_EN = 1'b1;
`else
    localparam bit c_ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   exp_cnt;
    exp_t mq[$];

    alu_issue_ctrl_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    alu_issue_ctrl #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode, table driven from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic f75, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] imm);
        exp_t e;
        int   alu_tab[8];
        int   br_tab[8];
        int   code;
        logic [31:0] src;
        bit   bad;
        alu_tab = '{2, 8, 4, 5, 6, 10, 1, 0};
        br_tab  = '{3, 3, -1, -1, 4, 4, 5, 5};
        bad = 1'b0;
        e.a = 0; e.b = 0; code = 2;
        case (opc)
            7'h33, 7'h13: begin
                code = alu_tab[f3];
                if (opc == 7'h33 && f3 == 3'd0 && f75) code = 3;
                if (f3 == 3'd5 && f75) code = 9;
                src = (opc == 7'h33) ? rs2 : imm;
                e.a = rs1;
                e.b = (code == 8 || code == 9 || code == 10) ? src % 32 : src;
            end
            7'h03, 7'h23: begin e.a = rs1; e.b = imm; end
            7'h63: begin
                code = br_tab[f3];
                if (code < 0) bad = 1'b1;
                else begin e.a = rs1; e.b = rs2; end
            end
            7'h37: e.b = imm;
            7'h17: begin e.a = pc; e.b = imm; end
            7'h6F, 7'h67: begin e.a = pc; e.b = 4; end
            default: bad = 1'b1;
        endcase
        if (bad) begin e.a = 0; e.b = 0; code = 2; end
        e.op  = 4'(code);
        e.ill = bad && c_ILL_EN;
        return e;
    endfunction

    task automatic model_update();
        bit   acc;
        exp_t e;
        if (rst || bus.flush) begin
            mq.delete();
            if (rst) exp_cnt = 0;
        end else begin
            acc = bus.in_valid && (mq.size() < 2);
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (acc) begin
                e = ref_decode(bus.opcode, bus.funct3, bus.funct7_5, bus.pc,
                               bus.rs1_data, bus.rs2_data, bus.imm);
                mq.push_back(e);
                if (e.ill) exp_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        check_eq("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_eq("alu_a", bus.alu_a, mq[0].a);
            check_eq("alu_b", bus.alu_b, mq[0].b);
            check_eq("alu_op", 32'(bus.alu_op), 32'(mq[0].op));
            check_eq("illegal", 32'(bus.illegal), 32'(mq[0].ill));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                             input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.pc       = pc;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
        bus.imm      = imm;
    endtask

    task automatic check_cnt(input string tag);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check_eq(tag, 32'(dut.illegal_cnt_q), 32'(exp_cnt));
`else
        if (tag.len() == 0) $display("empty counter tag");
`endif
    endtask

    logic [6:0] opc_tab[12];

    initial begin
        n_total = 0; n_bad = 0; exp_cnt = 0;
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67,
                    7'h7F, 7'h33, 7'h13};
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_instr(7'h0, 3'd0, 1'b0, 0, 0, 0, 0);
        tick(); tick();
        check_eq("rst_a", bus.alu_a, 32'h0);
        check_eq("rst_b", bus.alu_b, 32'h0);
        check_eq("rst_op", 32'(bus.alu_op), 32'h0);
        check_eq("rst_ill", 32'(bus.illegal), 32'h0);
        rst = 1'b0;
        tick();

        // OP SUB
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        set_instr(7'h33, 3'd0, 1'b1, 32'h0, 32'd7, 32'd3, 32'h0);
        tick();
        check_eq("sub_valid", 32'(bus.out_valid), 32'd1);
        check_eq("sub_op", 32'(bus.alu_op), 32'd3);
        check_eq("sub_a", bus.alu_a, 32'd7);
        check_eq("sub_b", bus.alu_b, 32'd3);

        // OP-IMM SRAI
        set_instr(7'h13, 3'd5, 1'b1, 32'h0, 32'h8000_0000, 32'h0, 32'h405);
        tick();
        check_eq("srai_op", 32'(bus.alu_op), 32'd9);
        check_eq("srai_b", bus.alu_b, 32'd5);

        // AUIPC then JAL
        set_instr(7'h17, 3'd0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h2000);
        tick();
        check_eq("auipc_op", 32'(bus.alu_op), 32'd2);
        check_eq("auipc_a", bus.alu_a, 32'h1000);
        check_eq("auipc_b", bus.alu_b, 32'h2000);
        set_instr(7'h6F, 3'd0, 1'b0, 32'h1004, 32'h0, 32'h0, 32'h0);
        tick();
        check_eq("jal_op", 32'(bus.alu_op), 32'd2);
        check_eq("jal_a", bus.alu_a, 32'h1004);
        check_eq("jal_b", bus.alu_b, 32'd4);

        // Back-pressure: four offers with out_ready low
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(7'h33, 3'd4, 1'b0, 32'h0, 32'(100 + i), 32'(i), 32'h0);
            tick();
            if (i == 1) check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check_eq("bp_head_a", bus.alu_a, 32'd100);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check_eq("bp_second_a", bus.alu_a, 32'd101);
        tick(); tick();
        check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

        // Flush while full with a concurrent offer
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        set_instr(7'h13, 3'd0, 1'b0, 32'h0, 32'd1, 32'h0, 32'd1);
        tick(); tick();
        bus.flush = 1'b1;
        tick();
        check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_ready", 32'(bus.in_ready), 32'd1);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();

        // Unsupported opcode
        bus.in_valid = 1'b1;
        set_instr(7'h7F, 3'd0, 1'b0, 32'h55, 32'h66, 32'h77, 32'h88);
        tick();
        bus.in_valid = 1'b0;
        check_eq("ill_flag", 32'(bus.illegal), 32'(c_ILL_EN));
        check_eq("ill_op", 32'(bus.alu_op), 32'd2);
        check_eq("ill_a", bus.alu_a, 32'd0);
        check_eq("ill_b", bus.alu_b, 32'd0);
        check_cnt("ill_cnt1");
        tick();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 149) == 0);
            set_instr(($urandom_range(0, 15) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 11)],
                      3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
            tick();
        end
        rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick(); tick(); tick();
        check_cnt("ill_cnt_end");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage front end that produces every input of the pipeline ALU: operand A, operand B and the 4-bit ALU opcode.
- Takes decoded-instruction fields and register/immediate data from ID over a valid/ready handshake.
- Maps RV32I opcode/funct3/funct7[5] onto the team ALU opcode encoding and selects operands.
- Presents the result from a registered, 2-entry skid-buffered output stage that feeds the ALU directly.

Parameters:
- XLEN, 32, datapath width of operands.
- OPW, 4, width of ALU opcode output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  kill all buffered entries (branch mispredict / trap)
- in_valid  input  1  ID offers an instruction
- in_ready  output  1  block can accept this cycle
- opcode  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7_5  input  1  instruction[30]
- pc  input  XLEN  instruction PC
- rs1_data  input  XLEN  forwarded rs1 value
- rs2_data  input  XLEN  forwarded rs2 value
- imm  input  XLEN  sign-extended immediate from ID
- out_valid  output  1  ALU inputs valid
- out_ready  input  1  EX/MEM accepts the current result
- alu_a  output  XLEN  ALU operand A
- alu_b  output  XLEN  ALU operand B
- alu_op  output  OPW  ALU opcode
- illegal  output  1  current entry is not a supported ALU-using instruction

Behaviour:
- ALU opcode encoding: AND=0, OR=1, ADD=2, SUB=3, SLT=4, SLTU=5, XOR=6, SLL=8, SRA=9, SRL=10. Codes 7 and 11-15 are never emitted.
- OP (0110011), b=rs2:
  - f3 000: ADD, or SUB if funct7_5
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR
  - 101: SRL, or SRA if funct7_5
  - 110 OR; 111 AND
- OP-IMM (0010011), b=imm: same mapping, except f3 000 is always ADD.
- Shifts (SLL/SRL/SRA from OP or OP-IMM): b = {27'b0, src[4:0]}.
- LOAD (0000011) and STORE (0100011): ADD, a=rs1, b=imm.
- BRANCH (1100011), a=rs1, b=rs2:
  - f3 000/001: SUB
  - 100/101: SLT
  - 110/111: SLTU
  - 010/011: unsupported
- LUI (0110111): ADD, a=0, b=imm.
- AUIPC (0010111): ADD, a=pc, b=imm.
- JAL (1101111) and JALR (1100111): ADD, a=pc, b=4 (link value).
- All other opcodes, and unsupported BRANCH f3: handled as in Optional Feature.
- Pipeline structure:
  - Main register plus one skid register; each holds {a, b, op, illegal}.
  - Outputs always come from the main register.
  - Latency: accepted in cycle N, visible on outputs in cycle N+1.
- in_ready = !skid_valid. It is registered and has no combinational path from out_ready.
- Accept: a transfer occurs when in_valid && in_ready.
  - Goes to main if main is empty or draining this cycle (out_ready).
  - Otherwise goes to skid.
- Drain: on out_valid && out_ready, main takes skid's contents if skid_valid, else takes the new accept, else becomes empty.
- Simultaneous accept and drain with skid empty: new entry goes to main; throughput stays 1 per cycle.
- Full (main and skid both valid): in_ready=0; in_valid is ignored.
- Empty: out_valid=0; data outputs hold their last value.
- flush: clears main_valid and skid_valid next cycle. It has priority over a same-cycle accept, which is dropped. out_valid=0 and in_ready=1 the cycle after.
- rst: same clearing as flush. All outputs reset: out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_op=0, illegal=0. Reset mid-stream discards all entries.
- Data is captured only on accept. No X propagation while empty.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_EN.
- Defined:
  - Unsupported encodings are accepted with alu_op=ADD, a=0, b=0 and illegal=1.
  - An internal 16-bit saturating counter of illegal accepts is readable on a hierarchical signal for the bench.
- Undefined: unsupported encodings are accepted as ADD, a=0, b=0; illegal is tied 0; no counter.

Test Plan:
- OP, f3=000, funct7_5=1, rs1=7, rs2=3, out_ready=1 -> next cycle out_valid=1, alu_op=3, alu_a=7, alu_b=3.
- OP-IMM, f3=101, funct7_5=1, rs1=0x80000000, imm=0x405 -> alu_op=9, alu_b=5.
- AUIPC pc=0x1000 imm=0x2000, then JAL pc=0x1004 on consecutive cycles -> alu_op=2 both; (a,b) = (0x1000,0x2000) then (0x1004,4).
- Four back-to-back instructions, out_ready held 0 -> in_ready falls after 2 accepts; release -> entries drain in order, no loss or duplication.
- Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and offered entries never appear.
- opcode 0x7F with ALU_ISSUE_ILLEGAL_EN -> illegal=1, alu_op=2, a=b=0, counter=1. Without the macro -> illegal=0, same data.
